pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Sits on the consumer side of the PLL lock interface. It takes the PLL's asynchronous `locked` output into the PLL output clock domain.
- It releases the design reset only after lock has been continuously stable and a hold-off time has elapsed.
- It re-asserts reset on any loss of lock and keeps a sticky flag plus a saturating count of lock-loss events for debug LEDs and UART status.

Parameters:
- SYNC_STAGES, 2, flip-flop stages synchronizing `locked` (legal >= 2).
- LOCK_STABLE_CYCLES, 1024, consecutive cycles synchronized lock must stay high before the hold phase (legal >= 1).
- RESET_HOLD_CYCLES, 16, cycles reset stays asserted after lock is qualified (legal >= 1).
- LOSS_COUNT_WIDTH, 8, width of the lock-loss event counter.

Ports:
- clock, input, 1, PLL output clock; the only clock.
- reset, input, 1, synchronous, active-high; restarts the whole sequence.
- locked, input, 1, raw PLL lock; asynchronous to `clock`.
- rst_out, output, 1, active-high reset to downstream logic.
- ready, output, 1, high exactly when rst_out is low.
- lock_lost, output, 1, sticky; set when lock drops while in RUN.
- loss_count, output, LOSS_COUNT_WIDTH, number of lock drops while in RUN; saturating.

Behaviour:
- Synchronizer: `locked` passes through SYNC_STAGES flops. Call the last stage lock_s.
- Reset:
  - reset=1 at an edge clears the sync flops, sets state to WAIT_LOCK and clears the counter.
  - Outputs after that edge: rst_out=1, ready=0, lock_lost=0, loss_count=0.
  - reset has priority over every other transition.
  - Reset mid-sequence or in RUN restarts from WAIT_LOCK, and the full sync, stabilize and hold latency applies again.
- State machine: one-hot states WAIT_LOCK, STABILIZE, HOLD, RUN.
  - Counter width is clog2(max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES)+1).
  - WAIT_LOCK: if lock_s=1, go to STABILIZE with cnt=0.
  - STABILIZE:
    - If lock_s=0, go to WAIT_LOCK.
    - Else if cnt==LOCK_STABLE_CYCLES-1, go to HOLD with cnt=0.
    - Else cnt++.
    - STABILIZE occupies exactly LOCK_STABLE_CYCLES cycles when lock stays high.
  - HOLD:
    - If lock_s=0, go to WAIT_LOCK.
    - Else if cnt==RESET_HOLD_CYCLES-1, go to RUN.
    - Else cnt++.
    - HOLD occupies exactly RESET_HOLD_CYCLES cycles.
  - RUN: if lock_s=0, go to WAIT_LOCK. On that same edge, set lock_lost=1 and increment loss_count, holding at all-ones.
  - Lock drops in STABILIZE or HOLD do not affect lock_lost or loss_count.
- Outputs are registered and updated on the same edge as the state:
  - rst_out = (state != RUN).
  - ready = (state == RUN).
  - No combinational path exists from `locked` to any output.
- Release latency: when `locked` is first sampled high at edge E and stays high, rst_out falls at edge E + SYNC_STAGES + LOCK_STABLE_CYCLES + RESET_HOLD_CYCLES.
- Assertion latency: when `locked` is first sampled low at edge E while in RUN, rst_out rises and ready falls at edge E + SYNC_STAGES.
- Glitches: a low pulse on `locked` that reaches lock_s for even one cycle restarts qualification. A high pulse shorter than LOCK_STABLE_CYCLES never releases reset.
- lock_lost and loss_count clear only on reset.

Test Plan:
1. SYNC_STAGES=2, LOCK_STABLE_CYCLES=4, RESET_HOLD_CYCLES=3. Assert reset for 2 cycles, then raise locked sampled at edge E -> rst_out=1 through edge E+8, rst_out=0 and ready=1 from edge E+9; lock_lost=0, loss_count=0.
2. Same parameters. During STABILIZE, drop locked for 1 cycle, then raise it again -> rst_out stays 1 and the full 9-edge release latency restarts from the new rising sample; lock_lost stays 0.
3. In RUN, drop locked at edge E -> rst_out=1 and ready=0 at edge E+2; lock_lost=1; loss_count=1. Restore lock -> release again after 9 edges; lock_lost stays 1.
4. LOSS_COUNT_WIDTH=2: 5 lock drops, each taken from RUN -> loss_count reads 1, 2, 3, 3, 3.
5. Assert reset while in RUN with lock_lost=1 and loss_count=2 -> the edge after reset shows rst_out=1, ready=0, lock_lost=0, loss_count=0. With locked held high, release occurs 9 edges after reset deasserts.
6. Pulse locked high for 3 cycles (shorter than LOCK_STABLE_CYCLES=4) -> rst_out never deasserts, and the state returns to WAIT_LOCK.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL lock qualifier: synchronizes locked, waits for stable lock plus a
// hold-off, then releases reset; tracks lock-loss events seen in RUN.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int LOSS_COUNT_WIDTH   = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        locked,
  output logic                        rst_out,
  output logic                        ready,
  output logic                        lock_lost,
  output logic [LOSS_COUNT_WIDTH-1:0] loss_count
);

  localparam int MAXC = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                        LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [3:0] {
    WAIT_LOCK = 4'b0001,
    STABILIZE = 4'b0010,
    HOLD      = 4'b0100,
    RUN       = 4'b1000
  } state_t;

  logic [SYNC_STAGES-1:0]      sync_q;
  logic                        lock_s;
  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        rst_q, rst_d;
  logic                        ready_q, ready_d;
  logic                        lost_q, lost_d;
  logic [LOSS_COUNT_WIDTH-1:0] loss_q, loss_d;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    loss_d  = loss_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STAB_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          lost_d  = 1'b1;
          if (loss_q != '1) loss_d = loss_q + 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    // outputs registered from next state so they move with the state
    rst_d   = (state_d != RUN);
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      rst_q   <= 1'b1;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
      loss_q  <= loss_d;
    end
  end

  assign rst_out    = rst_q;
  assign ready      = ready_q;
  assign lock_lost  = lost_q;
  assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed latency/sticky scenarios plus
// random lock traffic against a run-length reference model.
module tb_pll_reset_sequencer;

  localparam int SS = 2;
  localparam int LS = 4;
  localparam int HC = 3;
  localparam int LW = 2;
  localparam int REL = SS + LS + HC;
  localparam int RUNLEN = 1 + LS + HC;
  localparam int SAT = (1 << LW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          locked = 1'b0;
  logic          rst_out, ready, lock_lost;
  logic [LW-1:0] loss_count;

  pll_reset_sequencer #(
    .SYNC_STAGES(SS),
    .LOCK_STABLE_CYCLES(LS),
    .RESET_HOLD_CYCLES(HC),
    .LOSS_COUNT_WIDTH(LW)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .locked(locked),
    .rst_out(rst_out),
    .ready(ready),
    .lock_lost(lock_lost),
    .loss_count(loss_count)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference: lock as seen after the synchronizer delay, and the length
  // of the current unbroken run of seen-high cycles since reset
  int edges = 0;
  bit hist[$];
  bit mdl_on = 0;
  int run = 0;
  bit m_ready = 0;
  bit m_lost = 0;
  int m_loss = 0;

  always @(posedge clock) begin
    bit seen;
    edges++;
    if (reset) begin
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back(1'b0);
      mdl_on  = 1;
      run     = 0;
      m_ready = 0;
      m_lost  = 0;
      m_loss  = 0;
    end else begin
      seen = (hist.size() > 0) ? hist.pop_front() : 1'b0;
      hist.push_back(locked);
      if (seen) begin
        if (run < 100000) run++;
        m_ready = (run >= RUNLEN);
      end else begin
        if (m_ready) begin
          m_lost = 1;
          if (m_loss < SAT) m_loss++;
        end
        run     = 0;
        m_ready = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (mdl_on) begin
      chk("rst_out", 32'(rst_out), 32'(!m_ready));
      chk("ready", 32'(ready), 32'(m_ready));
      chk("lock_lost", 32'(lock_lost), 32'(m_lost));
      chk("loss_count", 32'(loss_count), 32'(m_loss));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // call right after driving an input at a negedge; E is the next edge
  task automatic wait_lvl(input string tag, input bit lvl, input int lat);
    int e;
    int k;
    e = edges + 1;
    k = 0;
    while (ready !== lvl && k < 40) begin
      @(negedge clock);
      k++;
    end
    chk(tag, 32'(edges - e), 32'(lat));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    cyc(n);
    reset = 1'b0;
  endtask

  int exp4[5] = '{1, 2, 3, 3, 3};
  int seen_rdy;

  initial begin
    cyc(2);
    chk("reset_rst", 32'(rst_out), 32'd1);
    chk("reset_cnt", 32'(loss_count), 32'd0);
    reset = 1'b0;

    // 1: basic release
    locked = 1'b1;
    wait_lvl("release_lat", 1'b1, REL);
    chk("release_lost", 32'(lock_lost), 32'd0);

    // 2: glitch during stabilize restarts qualification
    do_reset(2);
    locked = 1'b0;
    cyc(2);
    locked = 1'b1;
    cyc(4);
    locked = 1'b0;
    cyc(1);
    locked = 1'b1;
    wait_lvl("glitch_lat", 1'b1, REL);
    chk("glitch_lost", 32'(lock_lost), 32'd0);

    // 3: loss in RUN then relock
    locked = 1'b0;
    wait_lvl("loss_lat", 1'b0, SS);
    chk("loss_flag", 32'(lock_lost), 32'd1);
    chk("loss_cnt1", 32'(loss_count), 32'd1);
    locked = 1'b1;
    wait_lvl("relock_lat", 1'b1, REL);
    chk("relock_flag", 32'(lock_lost), 32'd1);

    // 4: saturating count
    do_reset(2);
    wait_lvl("sat_run", 1'b1, REL);
    for (int i = 0; i < 5; i++) begin
      locked = 1'b0;
      wait_lvl("sat_drop", 1'b0, SS);
      locked = 1'b1;
      wait_lvl("sat_rise", 1'b1, REL);
      chk("sat_cnt", 32'(loss_count), 32'(exp4[i]));
    end

    // 5: reset clears sticky state from RUN
    do_reset(2);
    wait_lvl("r5_run", 1'b1, REL);
    for (int i = 0; i < 2; i++) begin
      locked = 1'b0;
      wait_lvl("r5_drop", 1'b0, SS);
      locked = 1'b1;
      wait_lvl("r5_rise", 1'b1, REL);
    end
    chk("r5_cnt", 32'(loss_count), 32'd2);
    chk("r5_lost", 32'(lock_lost), 32'd1);
    reset = 1'b1;
    cyc(1);
    chk("r5_rst", 32'(rst_out), 32'd1);
    chk("r5_rdy", 32'(ready), 32'd0);
    chk("r5_lost0", 32'(lock_lost), 32'd0);
    chk("r5_cnt0", 32'(loss_count), 32'd0);
    cyc(1);
    reset = 1'b0;
    wait_lvl("r5_rel", 1'b1, REL);

    // 6: short high pulse never releases
    do_reset(2);
    locked = 1'b0;
    cyc(3);
    locked = 1'b1;
    cyc(LS - 1);
    locked = 1'b0;
    seen_rdy = 0;
    repeat (20) begin
      @(negedge clock);
      if (ready) seen_rdy++;
    end
    chk("short_pulse", 32'(seen_rdy), 32'd0);
    locked = 1'b1;
    wait_lvl("short_after", 1'b1, REL);

    // random lock traffic with occasional resets
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 2));
      locked = 1'($urandom_range(0, 1));
      cyc($urandom_range(1, 14));
    end
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
